// File: rtl/pixel_scan_ctrl.sv
// Raster-order frame scanner: walks a 1-bpp frame memory on start and presents pixels with line/frame markers.
// Read issued in cycle N yields pixel_out in N+2; no backpressure, the output stage must accept every valid pixel.
module pixel_scan_ctrl #(
    parameter int H_PIX   = 32,
    parameter int V_LINES = 16,
    parameter int H_BLANK = 4,
    parameter int ADDR_W  = 9
) (
    input  logic              clk_u,
    input  logic              rst_u,
    input  logic              start_in,
    output logic [ADDR_W-1:0] rd_addr_out,
    output logic              rd_en_out,
    input  logic              rd_data_in,
    output logic              pixel_out,
    output logic              pixel_valid_out,
    output logic              line_start_out,
    output logic              frame_start_out,
    output logic              busy_out,
    output logic              done_out
);

    localparam int COL_W = $clog2(H_PIX);
    localparam int ROW_W = (V_LINES > 1) ? $clog2(V_LINES) : 1;
    localparam int CNT_W = $clog2(H_BLANK + 2);

    localparam logic [COL_W-1:0] COL_LAST   = COL_W'(H_PIX - 1);
    localparam logic [ROW_W-1:0] ROW_LAST   = ROW_W'(V_LINES - 1);
    localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'((H_BLANK > 0) ? H_BLANK - 1 : 0);
    localparam logic [CNT_W-1:0] DRAIN_LAST = CNT_W'(1);

    generate
        if (H_PIX * V_LINES > 2 ** ADDR_W) begin : g_addr_too_narrow
            $error("pixel_scan_ctrl: H_PIX*V_LINES does not fit in ADDR_W address bits");
        end
        if (H_PIX < 2) begin : g_line_too_short
            $error("pixel_scan_ctrl: H_PIX must be at least 2");
        end
    endgenerate

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACTIVE = 2'd1,
        HBLANK = 2'd2,
        DRAIN  = 2'd3
    } state_t;

    state_t             state_q;
    logic [COL_W-1:0]   col_q;
    logic [ROW_W-1:0]   row_q;
    logic [ADDR_W-1:0]  addr_q;
    logic [CNT_W-1:0]   cnt_q;
    logic               rd_en_q;
    logic               ls_q;
    logic               fs_q;
    logic               busy_q;
    logic               done_q;

    logic               en_d1_q;
    logic               ls_d1_q;
    logic               fs_d1_q;
    logic               pix_q;
    logic               vld_q;
    logic               ls_out_q;
    logic               fs_out_q;

    // cnt_q is shared: blank length in HBLANK, flush length in DRAIN.
    always_ff @(posedge clk_u or posedge rst_u) begin
        if (rst_u) begin
            state_q <= IDLE;
            col_q   <= '0;
            row_q   <= '0;
            addr_q  <= '0;
            cnt_q   <= '0;
            rd_en_q <= 1'b0;
            ls_q    <= 1'b0;
            fs_q    <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start_in) begin
                        state_q <= ACTIVE;
                        col_q   <= '0;
                        row_q   <= '0;
                        addr_q  <= '0;
                        rd_en_q <= 1'b1;
                        ls_q    <= 1'b1;
                        fs_q    <= 1'b1;
                        busy_q  <= 1'b1;
                    end
                end
                ACTIVE: begin
                    fs_q <= 1'b0;
                    if (col_q == COL_LAST) begin
                        col_q <= '0;
                        if (row_q == ROW_LAST) begin
                            // Address stays on the last pixel; no wrap past the frame.
                            state_q <= DRAIN;
                            cnt_q   <= '0;
                            rd_en_q <= 1'b0;
                            ls_q    <= 1'b0;
                        end else begin
                            row_q  <= row_q + ROW_W'(1);
                            addr_q <= addr_q + ADDR_W'(1);
                            if (H_BLANK > 0) begin
                                state_q <= HBLANK;
                                cnt_q   <= '0;
                                rd_en_q <= 1'b0;
                                ls_q    <= 1'b0;
                            end else begin
                                rd_en_q <= 1'b1;
                                ls_q    <= 1'b1;
                            end
                        end
                    end else begin
                        col_q  <= col_q + COL_W'(1);
                        addr_q <= addr_q + ADDR_W'(1);
                        ls_q   <= 1'b0;
                    end
                end
                HBLANK: begin
                    if (cnt_q == BLANK_LAST) begin
                        state_q <= ACTIVE;
                        rd_en_q <= 1'b1;
                        ls_q    <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                DRAIN: begin
                    if (cnt_q == DRAIN_LAST) begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // Markers ride alongside the read strobe so they line up with the returned data.
    always_ff @(posedge clk_u or posedge rst_u) begin
        if (rst_u) begin
            en_d1_q  <= 1'b0;
            ls_d1_q  <= 1'b0;
            fs_d1_q  <= 1'b0;
            pix_q    <= 1'b0;
            vld_q    <= 1'b0;
            ls_out_q <= 1'b0;
            fs_out_q <= 1'b0;
        end else begin
            en_d1_q  <= rd_en_q;
            ls_d1_q  <= rd_en_q & ls_q;
            fs_d1_q  <= rd_en_q & fs_q;
            vld_q    <= en_d1_q;
            pix_q    <= en_d1_q & rd_data_in;
            ls_out_q <= ls_d1_q;
            fs_out_q <= fs_d1_q;
        end
    end

    assign rd_addr_out     = addr_q;
    assign rd_en_out       = rd_en_q;
    assign pixel_out       = pix_q;
    assign pixel_valid_out = vld_q;
    assign line_start_out  = ls_out_q;
    assign frame_start_out = fs_out_q;
    assign busy_out        = busy_q;
    assign done_out        = done_q;

endmodule

// File: tb/tb_pixel_scan_ctrl.sv
// Three scanner instances (4x2 blank 1, 4x2 blank 0, 32x16 blank 4) checked every cycle against
// a timing model derived from frame geometry, plus literal expectations for the first frame.
module tb_pixel_scan_ctrl;

    logic       clk_u = 1'b0;
    logic       rst_u;
    logic [2:0] st;
    logic [2:0] rdd;
    wire  [2:0] en, pix, vld, ls, fs, bsy, dn;
    wire  [2:0] addr_a, addr_b;
    wire  [8:0] addr_c;

    always #5 clk_u = ~clk_u;

    pixel_scan_ctrl #(.H_PIX(4), .V_LINES(2), .H_BLANK(1), .ADDR_W(3)) u_a (
        .clk_u(clk_u), .rst_u(rst_u), .start_in(st[0]), .rd_addr_out(addr_a), .rd_en_out(en[0]),
        .rd_data_in(rdd[0]), .pixel_out(pix[0]), .pixel_valid_out(vld[0]), .line_start_out(ls[0]),
        .frame_start_out(fs[0]), .busy_out(bsy[0]), .done_out(dn[0]));

    pixel_scan_ctrl #(.H_PIX(4), .V_LINES(2), .H_BLANK(0), .ADDR_W(3)) u_b (
        .clk_u(clk_u), .rst_u(rst_u), .start_in(st[1]), .rd_addr_out(addr_b), .rd_en_out(en[1]),
        .rd_data_in(rdd[1]), .pixel_out(pix[1]), .pixel_valid_out(vld[1]), .line_start_out(ls[1]),
        .frame_start_out(fs[1]), .busy_out(bsy[1]), .done_out(dn[1]));

    pixel_scan_ctrl #(.H_PIX(32), .V_LINES(16), .H_BLANK(4), .ADDR_W(9)) u_c (
        .clk_u(clk_u), .rst_u(rst_u), .start_in(st[2]), .rd_addr_out(addr_c), .rd_en_out(en[2]),
        .rd_data_in(rdd[2]), .pixel_out(pix[2]), .pixel_valid_out(vld[2]), .line_start_out(ls[2]),
        .frame_start_out(fs[2]), .busy_out(bsy[2]), .done_out(dn[2]));

    int HP[3] = '{4, 4, 32};
    int VL[3] = '{2, 2, 16};
    int HB[3] = '{1, 0, 4};

    bit mem[3][512];
    int cyc = 0;
    bit run[3];
    int s_cyc[3];
    int checks = 0;
    int errors = 0;

    function automatic int addr_of(input int d);
        case (d)
            0:       return int'(addr_a);
            1:       return int'(addr_b);
            default: return int'(addr_c);
        endcase
    endfunction

    // Cycles from the first read to the last read, inclusive.
    function automatic int frame_t(input int d);
        return HP[d] * VL[d] + (VL[d] - 1) * HB[d];
    endfunction

    function automatic int done_k(input int d);
        return frame_t(d) + 3;
    endfunction

    // k = cycles since the start was sampled; read slot j occupies line j/(H+B), column j%(H+B).
    function automatic void model(input int d, input int k, input bit act,
                                  output bit o_en, output int o_addr, output bit o_vld, output bit o_pix,
                                  output bit o_ls, output bit o_fs, output bit o_bsy, output bit o_dn);
        int h, p, t, j, r, c;
        h = HP[d];
        p = HP[d] + HB[d];
        t = frame_t(d);
        o_en = 0; o_addr = 0; o_vld = 0; o_pix = 0; o_ls = 0; o_fs = 0; o_bsy = 0; o_dn = 0;
        if (act) begin
            j = k - 1;
            if (j >= 0 && j < t) begin
                r = j / p; c = j % p;
                if (c < h) begin
                    o_en = 1; o_addr = r * h + c;
                end
            end
            j = k - 3;
            if (j >= 0 && j < t) begin
                r = j / p; c = j % p;
                if (c < h) begin
                    o_vld = 1; o_pix = mem[d][r * h + c]; o_ls = (c == 0); o_fs = (j == 0);
                end
            end
            o_bsy = (k >= 1) && (k <= t + 2);
            o_dn  = (k == t + 3);
        end
    endfunction

    always @(posedge clk_u) begin
        for (int d = 0; d < 3; d++) begin
            if (rst_u) begin
                run[d] = 0;
            end else if ((!run[d] || (cyc - s_cyc[d] >= done_k(d))) && st[d]) begin
                run[d]   = 1;
                s_cyc[d] = cyc;
            end else if (run[d] && (cyc - s_cyc[d] >= done_k(d))) begin
                run[d] = 0;
            end
        end
        cyc++;
    end

    // Synchronous-read frame memory; returns junk on idle cycles so stray pixels show up.
    always @(posedge clk_u) begin
        for (int d = 0; d < 3; d++)
            rdd[d] <= en[d] ? mem[d][addr_of(d)] : 1'($urandom);
    end

    task automatic chk(input string nm, input int d, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s dut%0d cyc=%0d got=%0d want=%0d", nm, d, cyc, act, exp);
        end
    endtask

    task automatic step();
        bit e_en, e_vld, e_pix, e_ls, e_fs, e_bsy, e_dn;
        int e_addr;
        @(negedge clk_u);
        for (int d = 0; d < 3; d++) begin
            if (rst_u) begin
                e_en = 0; e_addr = 0; e_vld = 0; e_pix = 0; e_ls = 0; e_fs = 0; e_bsy = 0; e_dn = 0;
            end else begin
                model(d, cyc - s_cyc[d], run[d], e_en, e_addr, e_vld, e_pix, e_ls, e_fs, e_bsy, e_dn);
            end
            chk("rd_en", d, int'(en[d]), int'(e_en));
            if (e_en || rst_u) chk("rd_addr", d, addr_of(d), e_addr);
            chk("pixel_valid", d, int'(vld[d]), int'(e_vld));
            chk("pixel", d, int'(pix[d]), int'(e_pix));
            chk("line_start", d, int'(ls[d]), int'(e_ls));
            chk("frame_start", d, int'(fs[d]), int'(e_fs));
            chk("busy", d, int'(bsy[d]), int'(e_bsy));
            chk("done", d, int'(dn[d]), int'(e_dn));
        end
    endtask

    int        s0, k;
    int        first_en_k, first_vld_k, done_a, done_b, done_c, nv_c, nls_c, np;
    int        qa[$];
    logic [7:0] pv;
    logic [7:0] img;
    int        last_dn, pend, ndc;

    initial begin
        img = 8'b1011_0110;
        for (int i = 0; i < 8; i++) begin
            mem[0][i] = img[i];
            mem[1][i] = img[i];
        end
        for (int i = 0; i < 512; i++) mem[2][i] = 1'($urandom_range(0, 1));

        rst_u = 1'b1;
        st    = 3'b000;
        repeat (3) step();
        rst_u = 1'b0;
        repeat (10) step();

        // Single start on all three instances; record the first frame for literal checks.
        first_en_k = -1; first_vld_k = -1; done_a = -1; done_b = -1; done_c = -1;
        nv_c = 0; nls_c = 0; np = 0; pv = '0;
        step();
        st = 3'b111;
        s0 = cyc;
        for (int i = 0; i < 600; i++) begin
            step();
            if (i == 0) st = 3'b000;
            k = cyc - s0;
            if (en[0]) begin
                if (first_en_k < 0) first_en_k = k;
                qa.push_back(int'(addr_a));
            end
            if (vld[0]) begin
                if (first_vld_k < 0) first_vld_k = k;
                if (np < 8) pv[np] = pix[0];
                np++;
            end
            if (dn[0] && done_a < 0) done_a = k;
            if (dn[1] && done_b < 0) done_b = k;
            if (dn[2] && done_c < 0) done_c = k;
            if (vld[2]) nv_c++;
            if (vld[2] && ls[2]) nls_c++;
        end
        chk("a_first_read_k", 0, first_en_k, 1);
        chk("a_first_valid_k", 0, first_vld_k, 3);
        chk("a_done_k", 0, done_a, 12);
        chk("a_read_count", 0, qa.size(), 8);
        for (int i = 0; i < 8; i++)
            if (i < qa.size()) chk("a_addr_seq", 0, qa[i], i);
        chk("a_valid_count", 0, np, 8);
        chk("a_pixel_bits", 0, int'(pv), 182);
        chk("b_done_k", 1, done_b, 11);
        chk("c_done_k", 2, done_c, 575);
        chk("c_valid_count", 2, nv_c, 512);
        chk("c_line_starts", 2, nls_c, 16);

        // Start held high: back-to-back frames, restart one cycle after done.
        last_dn = -1; pend = 0; ndc = 0;
        st = 3'b111;
        for (int i = 0; i < 1300; i++) begin
            step();
            if (pend && en[0]) begin
                chk("a_restart_gap", 0, cyc - last_dn, 1);
                pend = 0;
            end
            if (dn[0]) begin
                last_dn = cyc;
                pend = 1;
            end
            if (dn[2]) ndc++;
        end
        chk("c_frames_held_start", 2, ndc, 2);
        st = 3'b000;
        repeat (600) step();

        // Reset in the middle of a frame, then a fresh start from address 0.
        step();
        st = 3'b001;
        s0 = cyc;
        step();
        st = 3'b000;
        while (cyc < s0 + 4) step();
        rst_u = 1'b1;
        repeat (2) step();
        rst_u = 1'b0;
        repeat (20) step();
        st = 3'b001;
        step();
        st = 3'b000;
        chk("restart_rd_en", 0, int'(en[0]), 1);
        chk("restart_addr", 0, int'(addr_a), 0);
        repeat (20) step();

        // Random starts with occasional asynchronous resets.
        for (int i = 0; i < 2500; i++) begin
            if (rst_u) rst_u = 1'b0;
            else if ($urandom_range(0, 299) == 0) rst_u = 1'b1;
            for (int d = 0; d < 3; d++) st[d] = ($urandom_range(0, 7) == 0);
            step();
        end
        rst_u = 1'b0;
        st = 3'b000;
        repeat (600) step();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
